spi_mem_slave: RTL and testbench



---
 rtl/spi_mem_slave.sv | 195 +++++++++++++++++++
 tb/tb_spi_mem_slave.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_slave.sv
// rtl/spi_mem_slave.sv - SPI mode-0 byte memory target with parallel preload port (optional status read: SPI_MEM_STATUS_EN)
module spi_mem_slave #(
  parameter int AW          = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sclk,
  input  logic          cs_n,
  input  logic          mosi,
  output logic          miso,
  output logic          miso_oe,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [7:0]    load_data,
  output logic          load_ready
);

  localparam int AB = (AW + 7) / 8;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, WRITE, IGNORE} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   prev_sclk, prev_cs;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   rise, fall, cs_fall, byte_done;
  logic [6:0]             shift;
  logic [7:0]             byte_in, tx, reload;
  logic [2:0]             bit_cnt, fall_cnt;
  logic [3:0]             addr_cnt;
  logic [AW-1:0]          addr, addr_new, addr_inc;
  logic                   rd, miso_q;
  logic [7:0]             mem [2**AW];

`ifdef SPI_MEM_STATUS_EN
  logic       stat, write_seen;
  logic [3:0] wr_count;
  logic [7:0] status;
  assign status = {write_seen, 3'b000, wr_count};
  assign reload = stat ? status : mem[addr_inc];
`else
  assign reload = mem[addr_inc];
`endif

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign rise      = sclk_s & ~prev_sclk;
  assign fall      = ~sclk_s & prev_sclk;
  assign cs_fall   = prev_cs & ~cs_s;
  assign byte_in   = {shift, mosi_s};
  assign byte_done = rise && (bit_cnt == 3'd7);
  assign addr_new  = AW'({addr, byte_in});
  assign addr_inc  = addr + 1'b1;

  assign load_ready = (state == IDLE);
  assign miso_oe    = ~cs_s;
  assign miso       = miso_q & ~cs_s;

  // Bring the SPI pins into the clk domain and keep one cycle of history for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      prev_sclk <= 1'b0;
      prev_cs   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      prev_sclk <= sclk_s;
      prev_cs   <= cs_s;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode; a deasserted chip select always returns to IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (cs_fall) state_next = CMD;
      CMD: begin
        if (byte_done) begin
          case (byte_in)
            8'h03, 8'h02: state_next = ADDR;
`ifdef SPI_MEM_STATUS_EN
            8'h05:        state_next = READ;
`endif
            default:      state_next = IGNORE;
          endcase
        end
      end
      ADDR: if (byte_done && addr_cnt == 4'(AB - 1)) state_next = rd ? READ : WRITE;
      default: state_next = state;
    endcase
    if (state != IDLE && cs_s) state_next = IDLE;
  end

  // Bit/byte collection, address tracking and read-data serialization
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift    <= '0;
      bit_cnt  <= '0;
      fall_cnt <= '0;
      addr_cnt <= '0;
      addr     <= '0;
      tx       <= '0;
      rd       <= 1'b0;
      miso_q   <= 1'b0;
`ifdef SPI_MEM_STATUS_EN
      stat       <= 1'b0;
      write_seen <= 1'b0;
      wr_count   <= '0;
`endif
    end else if (state == IDLE) begin
      if (cs_fall) begin
        shift    <= '0;
        bit_cnt  <= '0;
        fall_cnt <= '0;
        addr_cnt <= '0;
        addr     <= '0;
        miso_q   <= 1'b0;
`ifdef SPI_MEM_STATUS_EN
        stat     <= 1'b0;
`endif
      end
    end else begin
      if (rise) begin
        shift   <= byte_in[6:0];
        bit_cnt <= bit_cnt + 3'd1;
      end
      case (state)
        CMD: begin
          if (byte_done) begin
            rd <= (byte_in == 8'h03);
`ifdef SPI_MEM_STATUS_EN
            if (byte_in == 8'h05) begin
              stat     <= 1'b1;
              tx       <= status;
              fall_cnt <= '0;
            end
`endif
          end
        end
        ADDR: begin
          if (byte_done) begin
            addr     <= addr_new;
            addr_cnt <= addr_cnt + 4'd1;
            tx       <= mem[addr_new];
            fall_cnt <= '0;
          end
        end
        READ: begin
          if (fall) begin
            miso_q   <= tx[7];
            tx       <= {tx[6:0], 1'b0};
            fall_cnt <= fall_cnt + 3'd1;
            if (fall_cnt == 3'd7) begin
              addr <= addr_inc;
              tx   <= reload;
            end
          end
        end
        WRITE: begin
          if (byte_done) begin
            addr <= addr_inc;
`ifdef SPI_MEM_STATUS_EN
            write_seen <= 1'b1;
            wr_count   <= wr_count + 4'd1;
`endif
          end
        end
        default: ;
      endcase
      if (cs_s) miso_q <= 1'b0;
    end
  end

  // Memory writes: parallel preload in IDLE, SPI data bytes in WRITE (even if cs_n rises that cycle)
  always_ff @(posedge clk) begin
    if (!rst && load_en && load_ready)
      mem[load_addr] <= load_data;
    else if (!rst && state == WRITE && byte_done)
      mem[addr] <= byte_in;
  end

endmodule

// File: tb/tb_spi_mem_slave.sv
// tb/tb_spi_mem_slave.sv - randomized bench for spi_mem_slave against a byte-array memory model
module tb_spi_mem_slave;

  logic       clk = 1'b0;
  logic       rst, sclk, cs_n, mosi, load_en;
  logic [7:0] load_addr, load_data;
  logic       miso, miso_oe, load_ready;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model [256];
  int         wr_total = 0;

  always #5 clk = ~clk;

  spi_mem_slave #(.AW(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .load_ready(load_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d, input bit accept);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    chk("load_ready", load_ready, accept);
    load_en = 1'b0;
    if (accept) model[a] = d;
    @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      wait_clk(8);
      rx = {rx[6:0], miso};
      sclk = 1'b1;
      wait_clk(8);
      sclk = 1'b0;
    end
  endtask

  task automatic frame_begin();
    cs_n = 1'b0;
    wait_clk(6);
    chk("oe_active", miso_oe, 1'b1);
  endtask

  task automatic frame_end();
    wait_clk(6);
    cs_n = 1'b1;
    wait_clk(8);
    chk("oe_idle", miso_oe, 1'b0);
    chk("miso_idle", miso, 1'b0);
  endtask

  task automatic spi_read(input logic [7:0] a, input int n);
    logic [7:0] rx;
    logic [7:0] ea;
    frame_begin();
    xfer(8'h03, 8, rx);
    xfer(a, 8, rx);
    for (int k = 0; k < n; k++) begin
      ea = a + 8'(k);
      xfer(8'($urandom), 8, rx);
      chk($sformatf("read[%0h]", ea), rx, model[ea]);
    end
    frame_end();
  endtask

  task automatic spi_write(input logic [7:0] a, input logic [31:0] data, input int n);
    logic [7:0] rx;
    logic [7:0] ea;
    frame_begin();
    xfer(8'h02, 8, rx);
    xfer(a, 8, rx);
    for (int k = 0; k < n; k++) begin
      ea = a + 8'(k);
      xfer(data[8*k +: 8], 8, rx);
      model[ea] = data[8*k +: 8];
      wr_total++;
    end
    frame_end();
  endtask

  initial begin
    logic [7:0] rx;
    logic [7:0] exp_status;
    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    wait_clk(3);
    chk("rst_miso", miso, 1'b0);
    chk("rst_oe", miso_oe, 1'b0);
    chk("rst_load_ready", load_ready, 1'b1);
    rst = 1'b0;
    wait_clk(4);

    for (int i = 0; i < 256; i++) load(8'(i), 8'($urandom), 1'b1);
    load(8'h10, 8'hA5, 1'b1);
    load(8'h11, 8'h3C, 1'b1);

    // basic read of preloaded bytes
    spi_read(8'h10, 2);

    // write across the top of memory, read back including the wrap
    spi_write(8'hFE, 32'h0033_2211, 3);
    spi_read(8'hFE, 3);
    spi_read(8'h00, 1);
    chk("wrap_byte", model[8'h00], 8'h33);

    // unknown command keeps miso low
    frame_begin();
    xfer(8'h9F, 8, rx);
    for (int k = 0; k < 3; k++) begin
      xfer(8'($urandom), 8, rx);
      chk("ignore_miso", rx, 8'h00);
    end
    frame_end();
    spi_read(8'h10, 1);

    // partial data byte is discarded
    frame_begin();
    xfer(8'h02, 8, rx);
    xfer(8'h20, 8, rx);
    xfer(8'($urandom), 5, rx);
    frame_end();
    spi_read(8'h20, 1);
    spi_read(8'h21, 1);

    // load port blocked during an active transaction
    frame_begin();
    xfer(8'h03, 8, rx);
    xfer(8'h10, 8, rx);
    load(8'h10, 8'h5A, 1'b0);
    xfer(8'h00, 8, rx);
    chk("read_during_load", rx, 8'hA5);
    frame_end();
    load(8'h10, 8'h5A, 1'b1);
    spi_read(8'h10, 1);
    load(8'h10, 8'hA5, 1'b1);

    // reset in the middle of a read
    frame_begin();
    xfer(8'h03, 8, rx);
    xfer(8'h11, 8, rx);
    xfer(8'h00, 4, rx);
    rst = 1'b1;
    #1;
    chk("midrst_miso", miso, 1'b0);
    chk("midrst_oe", miso_oe, 1'b0);
    chk("midrst_load_ready", load_ready, 1'b1);
    @(negedge clk);
    cs_n = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(8);
    wr_total = 0;
    spi_read(8'h10, 2);

    // status command (unknown command when the status feature is compiled out)
    spi_write(8'h40, 32'h00C3_B2A1, 3);
`ifdef SPI_MEM_STATUS_EN
    exp_status = {(wr_total > 0) ? 1'b1 : 1'b0, 3'b000, 4'(wr_total)};
`else
    exp_status = 8'h00;
`endif
    frame_begin();
    xfer(8'h05, 8, rx);
    for (int k = 0; k < 2; k++) begin
      xfer(8'($urandom), 8, rx);
      chk("status", rx, exp_status);
    end
    frame_end();

    // randomized traffic
    for (int it = 0; it < 24; it++) begin
      int op;
      int n;
      logic [7:0] a;
      op = $urandom_range(0, 2);
      n  = $urandom_range(1, 4);
      a  = 8'($urandom);
      case (op)
        0: spi_read(a, n);
        1: spi_write(a, $urandom, n);
        default: load(a, 8'($urandom), 1'b1);
      endcase
    end
    spi_read(8'hFC, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
